// File: rtl/heartbeat_led_gen.sv
// Heartbeat status-LED pattern generator: a 16-phase blink period built from a
// TICK_DIV prescaler, with selectable patterns, a fault fast-blink override and a period strobe.
module heartbeat_led_gen #(
  parameter int TICK_DIV = 8_000_000
) (
  input  logic       clk_128M,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       fault,
  output logic       led,
  output logic       period_tick
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre_reg;
  logic [3:0]       phase_reg;
  logic             led_reg;
  logic             led_next;
  logic             tick_reg;
  logic             phase_adv;

  // Per-phase lookup masks, indexed by the current phase.
  logic [15:0] square_pat;
  logic [15:0] heart_pat;
  logic [15:0] fault_pat;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_pat
      assign square_pat[gi] = (gi < 8);
      assign heart_pat[gi]  = (gi == 0) || (gi == 2);
      assign fault_pat[gi]  = ((gi % 4) < 2);
    end
  endgenerate

  assign phase_adv = (pre_reg == PRE_LAST);

  always_comb begin
    led_next = 1'b0;
    if (fault) begin
      led_next = fault_pat[phase_reg];
    end else begin
      case (mode)
        2'd0:    led_next = 1'b0;
        2'd1:    led_next = 1'b1;
        2'd2:    led_next = square_pat[phase_reg];
        default: led_next = heart_pat[phase_reg];
      endcase
    end
  end

  // Phase is free-running; only reset restarts it, never a mode or fault change.
  always_ff @(posedge clk_128M) begin
    if (!rst_n) begin
      pre_reg   <= '0;
      phase_reg <= 4'd0;
      led_reg   <= 1'b0;
      tick_reg  <= 1'b0;
    end else begin
      pre_reg  <= phase_adv ? '0 : pre_reg + PRE_W'(1);
      if (phase_adv) begin
        phase_reg <= phase_reg + 4'd1;
      end
      led_reg  <= led_next;
      tick_reg <= phase_adv && (phase_reg == 4'd15);
    end
  end

  assign led         = led_reg;
  assign period_tick = tick_reg;

endmodule

// File: tb/tb_heartbeat_led_gen.sv
// Directed-vector and randomized reference-model bench for heartbeat_led_gen (TICK_DIV = 4).
module tb_heartbeat_led_gen;

  localparam int TD = 4;

  logic       clk_128M = 1'b0;
  logic       rst_n    = 1'b0;
  logic [1:0] mode     = 2'd1;
  logic       fault    = 1'b0;
  logic       led;
  logic       period_tick;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk_128M = ~clk_128M;

  heartbeat_led_gen #(.TICK_DIV(TD)) dut (
    .clk_128M    (clk_128M),
    .rst_n       (rst_n),
    .mode        (mode),
    .fault       (fault),
    .led         (led),
    .period_tick (period_tick)
  );

  typedef struct {
    int         n;
    bit         rst_n;
    logic [1:0] mode;
    bit         fault;
    bit         exp_led;
    bit         exp_tick;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string nm, input logic exp_led, input logic exp_tick);
    n_vec++;
    if (led !== exp_led || period_tick !== exp_tick) begin
      n_bad++;
      $display("FAIL %s: got led=%b tick=%b, want led=%b tick=%b",
               nm, led, period_tick, exp_led, exp_tick);
    end else begin
      $display("ok   %s: led=%b tick=%b", nm, led, period_tick);
    end
  endtask

  // Reference model state
  int  m_pre, m_phase;
  bit  m_led, m_tick;

  function automatic bit model_f(input int ph, input logic [1:0] md, input bit flt);
    if (flt) return ((ph % 4) < 2);
    case (md)
      2'd0: return 1'b0;
      2'd1: return 1'b1;
      2'd2: return (ph < 8);
      default: return (ph == 0 || ph == 2);
    endcase
  endfunction

  task automatic stress(input int total);
    int cyc;
    int last_tick;
    int seg;
    int seg_bad;
    rst_n = 1'b0;
    @(posedge clk_128M);
    #1;
    m_pre = 0; m_phase = 0; m_led = 0; m_tick = 0;
    check("stress_reset", m_led, m_tick);
    rst_n     = 1'b1;
    cyc       = 0;
    last_tick = 0;
    while (cyc < total) begin
      seg     = $urandom_range(1, 50);
      mode    = 2'($urandom_range(0, 3));
      fault   = ($urandom_range(0, 3) == 0);
      seg_bad = n_bad;
      for (int i = 0; i < seg; i++) begin
        @(posedge clk_128M);
        cyc++;
        m_led  = model_f(m_phase, mode, fault);
        m_tick = (m_pre == TD - 1) && (m_phase == 15);
        if (m_pre == TD - 1) begin
          m_pre   = 0;
          m_phase = (m_phase + 1) % 16;
        end else begin
          m_pre = m_pre + 1;
        end
        #1;
        n_vec++;
        if (led !== m_led || period_tick !== m_tick) begin
          n_bad++;
          $display("FAIL stress_cyc%0d: got led=%b tick=%b, want led=%b tick=%b",
                   cyc, led, period_tick, m_led, m_tick);
        end
        if (period_tick === 1'b1) begin
          n_vec++;
          if (cyc - last_tick != 64) begin
            n_bad++;
            $display("FAIL tick_spacing: got %0d cycles, want 64", cyc - last_tick);
          end
          last_tick = cyc;
        end
      end
      $display("seg  cyc=%0d len=%0d mode=%0d fault=%0b errors=%0d",
               cyc, seg, mode, fault, n_bad - seg_bad);
    end
  endtask

  initial begin
    // Columns: edges to run, rst_n, mode, fault, expected led, expected period_tick.
    vt.push_back('{1,  1'b1, 2'd1, 1'b0, 1'b1, 1'b0});  // E1
    vt.push_back('{18, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0});  // E19
    vt.push_back('{1,  1'b1, 2'd0, 1'b0, 1'b0, 1'b0});  // E20
    vt.push_back('{1,  1'b1, 2'd2, 1'b0, 1'b1, 1'b0});  // E21
    vt.push_back('{11, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0});  // E32 last high
    vt.push_back('{1,  1'b1, 2'd2, 1'b0, 1'b0, 1'b0});  // E33 first low
    vt.push_back('{31, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1});  // E64 strobe
    vt.push_back('{1,  1'b1, 2'd2, 1'b0, 1'b1, 1'b0});  // E65
    vt.push_back('{1,  1'b1, 2'd3, 1'b0, 1'b1, 1'b0});  // E66 phase 0
    vt.push_back('{3,  1'b1, 2'd3, 1'b0, 1'b0, 1'b0});  // E69 phase 1
    vt.push_back('{3,  1'b1, 2'd3, 1'b0, 1'b0, 1'b0});  // E72 phase 1
    vt.push_back('{1,  1'b1, 2'd3, 1'b0, 1'b1, 1'b0});  // E73 phase 2
    vt.push_back('{3,  1'b1, 2'd3, 1'b0, 1'b1, 1'b0});  // E76 phase 2
    vt.push_back('{1,  1'b1, 2'd3, 1'b0, 1'b0, 1'b0});  // E77 phase 3
    vt.push_back('{1,  1'b1, 2'd1, 1'b1, 1'b0, 1'b0});  // E78 fault, phase 3
    vt.push_back('{3,  1'b1, 2'd1, 1'b1, 1'b1, 1'b0});  // E81 phase 4
    vt.push_back('{8,  1'b1, 2'd1, 1'b1, 1'b0, 1'b0});  // E89 phase 6
    vt.push_back('{1,  1'b1, 2'd1, 1'b0, 1'b1, 1'b0});  // E90 fault released
    vt.push_back('{1,  1'b1, 2'd0, 1'b1, 1'b0, 1'b0});  // E91 phase 6
    vt.push_back('{4,  1'b1, 2'd0, 1'b1, 1'b0, 1'b0});  // E95 phase 7
    vt.push_back('{2,  1'b1, 2'd0, 1'b1, 1'b1, 1'b0});  // E97 fault beats mode 0
    vt.push_back('{1,  1'b1, 2'd0, 1'b0, 1'b0, 1'b0});  // E98
    vt.push_back('{30, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1});  // E128 strobe
    vt.push_back('{1,  1'b1, 2'd1, 1'b0, 1'b1, 1'b0});  // E129
    vt.push_back('{1,  1'b0, 2'd1, 1'b0, 1'b0, 1'b0});  // mid-phase reset
    vt.push_back('{1,  1'b1, 2'd2, 1'b0, 1'b1, 1'b0});  // E1
    vt.push_back('{8,  1'b1, 2'd3, 1'b0, 1'b1, 1'b0});  // E9 phase 2
    vt.push_back('{55, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1});  // E64 strobe after restart

    rst_n = 1'b0;
    mode  = 2'd1;
    fault = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_128M);
      #1;
      check($sformatf("reset%0d", i), 1'b0, 1'b0);
    end

    for (int i = 0; i < vt.size(); i++) begin
      rst_n = vt[i].rst_n;
      mode  = vt[i].mode;
      fault = vt[i].fault;
      repeat (vt[i].n) @(posedge clk_128M);
      #1;
      check($sformatf("vec%0d", i), vt[i].exp_led, vt[i].exp_tick);
    end

    stress(10000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
